apb_mst_arbiter: RTL

APB master that shares one APB bus among NUM_REQ internal requesters, e.g. bench agents or firmware ports that drive the APB dual-port memory slave.
- Per-requester valid/ready command channel in; round-robin arbitration; one APB transfer at a time (SETUP then ACCESS).
- Response (read data, error) is returned only to the requester that owns the transfer.

---
 rtl/apb_mst_arbiter_pkg.sv | 23 ++
 rtl/apb_mst_arbiter_rr_arbiter.sv | 47 ++++
 rtl/apb_mst_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/apb_mst_arbiter_pkg.sv
// Shared types for the APB master arbiter: bus widths, FSM states and
// the per-requester command record.
package apb_mst_arbiter_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_mst_arbiter_rr_arbiter.sv
// Round-robin winner selection. Purely combinational: the caller owns the
// pointer register and feeds back ptr_next, which moves just past the
// winner only when adv (an accept cycle) coincides with a pending request.
module apb_mst_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               adv,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any,
    output logic [IDX_W-1:0]   ptr_next
);

    // Scan ptr, ptr+1, ... modulo NUM_REQ and take the first active request.
    always_comb begin
        int cand;
        logic found;
        cand     = 0;
        found    = 1'b0;
        idx      = '0;
        grant    = '0;
        ptr_next = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
        any = found;
        if (adv && found) begin
            grant[idx] = 1'b1;
            if (int'(idx) == NUM_REQ - 1) begin
                ptr_next = '0;
            end else begin
                ptr_next = idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_mst_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin command accept,
// one SETUP/ACCESS transfer at a time, response routed back to the owner.
// Build option: define APB_TIMEOUT_EN to abort an ACCESS phase that has
// waited TIMEOUT_CYCLES cycles without PREADY (owner gets rsp_err=1).
module apb_mst_arbiter
    import apb_mst_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output data_t                        rsp_rdata,
    output logic                         rsp_err,
    output logic                         PSEL,
    output logic                         PENABLE,
    output addr_t                        PADDR,
    output logic                         PWRITE,
    output data_t                        PWDATA,
    input  logic                         PREADY,
    input  data_t                        PRDATA,
    input  logic                         PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Marker block: only elaborates for parameter values outside the supported range.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_out_of_range
    end

    apb_state_e        state_reg, state_next;
    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic [IDX_W-1:0]  win_idx, grant_idx_reg;
    logic              any_req, accept, fire, done, timeout;
    apb_req_t          req_cmd [NUM_REQ];
    apb_req_t          win_cmd;
    addr_t             paddr_reg;
    data_t             pwdata_reg, rsp_rdata_reg;
    logic              pwrite_reg, rsp_err_reg;
    logic [NUM_REQ-1:0] rsp_valid_reg;

    // Unpack the flat command buses into one record per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_cmd[gi].write = req_write[gi];
        assign req_cmd[gi].addr  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_cmd[gi].wdata = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // A new command may be taken when idle or on the completing ACCESS cycle.
    assign done    = (state_reg == ACCESS) && PREADY;
    assign accept  = PRESETn && ((state_reg == IDLE) || done);
    assign fire    = accept && any_req;
    assign win_cmd = req_cmd[win_idx];

    apb_mst_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req      (req_valid),
        .ptr      (ptr_reg),
        .adv      (accept),
        .grant    (req_ready),
        .idx      (win_idx),
        .any      (any_req),
        .ptr_next (ptr_next)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_reg;

    // Count ACCESS cycles of the current transfer; SETUP starts a fresh count.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt_reg <= '0;
        end else if (state_reg == SETUP) begin
            to_cnt_reg <= '0;
        end else if (state_reg == ACCESS && !PREADY) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    assign timeout = (state_reg == ACCESS) && !PREADY &&
                     (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State, pointer, command and response registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_idx_reg <= '0;
            paddr_reg     <= '0;
            pwrite_reg    <= 1'b0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            rsp_valid_reg <= '0;
            if (fire) begin
                grant_idx_reg <= win_idx;
                paddr_reg     <= win_cmd.addr;
                pwrite_reg    <= win_cmd.write;
                pwdata_reg    <= win_cmd.wdata;
            end else if (done || timeout) begin
                // Returning to IDLE: the bus is driven low there.
                paddr_reg  <= '0;
                pwrite_reg <= 1'b0;
                pwdata_reg <= '0;
            end
            if (done || timeout) begin
                rsp_valid_reg <= NUM_REQ'(1) << grant_idx_reg;
                rsp_err_reg   <= timeout | PSLVERR;
                rsp_rdata_reg <= (timeout || pwrite_reg) ? '0 : PRDATA;
            end
        end
    end

    // Next-state logic for the SETUP/ACCESS sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_next = any_req ? SETUP : IDLE;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign PSEL      = (state_reg != IDLE);
    assign PENABLE   = (state_reg == ACCESS);
    assign PADDR     = paddr_reg;
    assign PWRITE    = pwrite_reg;
    assign PWDATA    = pwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
